// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard hazard detection and stall/flush control beside ID
module pipe_hazard_ctrl #(
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [63:0]      id_pc,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic             rs1_ren,
    input  logic             rs2_ren,
    input  logic [4:0]       rd_addr,
    input  logic             rd_wen,
    input  logic             id_long,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             redirect,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             issue,
    output logic [CNT_W-1:0] pending_cnt,
    output logic [31:0]      stall_cycles
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic [31:0] sb;
    logic [31:0] clr;
    logic [31:0] pend;
    logic [31:0] set_vec;
    logic        id_ok;
    logic        wb_frees;
    logic        cap_full;
    logic        hazard;

    always_comb begin
        clr = '0;
        if (wb_valid)
            clr[wb_rd] = 1'b1;
    end

    // A same-cycle writeback is forwarded, so it no longer blocks operands.
    assign pend     = sb & ~clr;
    assign id_ok    = id_valid && (id_pc != 64'h0) && (id_pc != 64'h0000_0000_8000_0000);
    assign wb_frees = wb_valid & sb[wb_rd];
    assign cap_full = (pending_cnt == CNT_W'(MAX_PENDING)) & ~wb_frees;

    assign hazard = id_ok & ((rs1_ren & pend[rs1_addr]) |
                             (rs2_ren & pend[rs2_addr]) |
                             (rd_wen  & pend[rd_addr])  |
                             (id_long & rd_wen & cap_full));

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < 32; i++)
            pending_cnt = pending_cnt + CNT_W'(sb[i]);
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        issue       = 1'b0;
        if (rst_n) begin
            if (state == S_FLUSH || redirect) begin
                flush_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end else begin
                stall_if  = hazard;
                stall_id  = hazard;
                bubble_ex = hazard;
                issue     = id_ok & ~hazard;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        if (issue && id_long && rd_wen && rd_addr != 5'd0)
            set_vec[rd_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb           <= '0;
            stall_cycles <= '0;
        end else begin
            sb <= ((sb & ~clr) | set_vec) & ~32'h1;
            if (stall_id && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    // Each redirect keeps flush_if_id high for its own cycle plus FLUSH_CYCLES-1 more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            flush_cnt <= '0;
        end else if (redirect) begin
            state     <= (FLUSH_LOAD != 3'd0) ? S_FLUSH : S_RUN;
            flush_cnt <= FLUSH_LOAD;
        end else if (state == S_FLUSH) begin
            if (flush_cnt <= 3'd1) begin
                state     <= S_RUN;
                flush_cnt <= '0;
            end else begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    wb_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) wb_valid |-> sb[wb_rd]);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam logic [63:0] P = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_rd;
    logic        rs1_ren, rs2_ren, rd_wen, id_long, wb_valid, redirect;
    logic        stall_if, stall_id, bubble_ex, flush_if_id, issue;
    logic [2:0]  pending_cnt;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        iv;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic        r1e;
        logic [4:0]  rs2;
        logic        r2e;
        logic [4:0]  rd;
        logic        we;
        logic        lg;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        rdr;
        logic        e_stall;
        logic        e_bub;
        logic        e_flush;
        logic        e_issue;
        logic [2:0]  e_cnt;
        logic [31:0] e_sc;
    } vec_t;

    vec_t tbl[$];
    vec_t hand[$];

    pipe_hazard_ctrl #(.MAX_PENDING(4), .FLUSH_CYCLES(2), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_ren(rs1_ren), .rs2_ren(rs2_ren),
        .rd_addr(rd_addr), .rd_wen(rd_wen), .id_long(id_long), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .redirect(redirect), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .issue(issue),
        .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic iv, logic [63:0] pc, logic [4:0] rs1, logic r1e,
                                logic [4:0] rs2, logic r2e, logic [4:0] rd, logic we, logic lg,
                                logic wbv, logic [4:0] wbrd, logic rdr,
                                logic st, logic bub, logic fl, logic iss,
                                logic [2:0] cnt, logic [31:0] sc);
        vec_t v;
        v.iv = iv; v.pc = pc; v.rs1 = rs1; v.r1e = r1e; v.rs2 = rs2; v.r2e = r2e;
        v.rd = rd; v.we = we; v.lg = lg; v.wbv = wbv; v.wbrd = wbrd; v.rdr = rdr;
        v.e_stall = st; v.e_bub = bub; v.e_flush = fl; v.e_issue = iss;
        v.e_cnt = cnt; v.e_sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.iv;  id_pc = v.pc;
        rs1_addr = v.rs1; rs1_ren = v.r1e;
        rs2_addr = v.rs2; rs2_ren = v.r2e;
        rd_addr  = v.rd;  rd_wen  = v.we;  id_long = v.lg;
        wb_valid = v.wbv; wb_rd   = v.wbrd; redirect = v.rdr;
    endtask

    task automatic check_outs(input vec_t v, input int idx);
        chk("stall_if",     idx, 32'(stall_if),    32'(v.e_stall));
        chk("stall_id",     idx, 32'(stall_id),    32'(v.e_stall));
        chk("bubble_ex",    idx, 32'(bubble_ex),   32'(v.e_bub));
        chk("flush_if_id",  idx, 32'(flush_if_id), 32'(v.e_flush));
        chk("issue",        idx, 32'(issue),       32'(v.e_issue));
        chk("pending_cnt",  idx, 32'(pending_cnt), 32'(v.e_cnt));
        chk("stall_cycles", idx, stall_cycles,     v.e_sc);
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        check_outs(v, idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // load-use on x5
        tbl.push_back(mk(1, P, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, P, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, P, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0,   1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, P, 5, 1, 1, 1, 6, 1, 0, 1, 5, 0,   0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2));
        // same-cycle clear and set of x7
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0,   0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, P, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0,   1, 1, 0, 0, 1, 2));
        tbl.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 0, 1, 3));
        // capacity
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,   0, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 0, 0, 1, 2, 3));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,   0, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0,   1, 1, 0, 0, 4, 3));
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 8, 1, 1, 1, 2, 0,   0, 0, 0, 1, 4, 4));
        tbl.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, 4));
        // x0 destination and PC filter
        tbl.push_back(mk(1, P, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0,   0, 0, 0, 1, 4, 4));
        tbl.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 64'h8000_0000, 3, 1, 0, 0, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 64'h0, 3, 1, 0, 0, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, P, 3, 1, 0, 0, 9, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3, 4));

        // redirect over a hazard, then a double redirect extending the flush
        hand.push_back(mk(1, P, 3, 1, 0, 0, 9, 1, 0, 0, 0, 1,   0, 1, 1, 0, 3, 5));
        hand.push_back(mk(1, P, 3, 1, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5));
        hand.push_back(mk(1, P, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 5));
        hand.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 3, 5));
        hand.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 3, 5));
        hand.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5));
        hand.push_back(mk(1, P, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 5));
        hand.push_back(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 3, 5));

        // reset with redirect and a valid instruction presented: outputs must stay low
        rst_n = 1'b0;
        drive(mk(1, P, 3, 1, 0, 0, 9, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0), 900);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);
        for (int i = 0; i < hand.size(); i++)
            apply(hand[i], 100 + i);

        // now in FLUSH with x3, x4, x8 pending; reset asynchronously mid-cycle
        drive(mk(1, P, 3, 1, 0, 0, 9, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
        chk("pre_reset_flush", 200, 32'(flush_if_id), 32'd1);
        chk("pre_reset_cnt",   200, 32'(pending_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        check_outs(mk(0, P, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0), 201);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(1, P, 3, 1, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0), 202);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
